// File: rtl/gt_bitserial_pkg.sv
// Shared types for the bit-serial unsigned comparator: opcode encoding and FSM states.
package gt_bitserial_pkg;

  typedef enum logic [1:0] {
    OP_GT = 2'd0,
    OP_GE = 2'd1,
    OP_LT = 2'd2,
    OP_LE = 2'd3
  } cmp_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_borrow_cell.sv
// One-bit borrow cell for z - x - bin; the only datapath cell, reused every BUSY cycle.
module sub_borrow_cell (
  input  logic x,
  input  logic z,
  input  logic bin,
  output logic bout
);

  assign bout = (~z & x) | (~(z ^ x) & bin);

endmodule

// File: rtl/gt_uint_bitserial_ctrl.sv
// Bit-serial unsigned compare: captures A/B/op, walks LSB to MSB through one borrow cell,
// and returns the final borrow as Y over a valid/ready handshake.
module gt_uint_bitserial_ctrl
  import gt_bitserial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_z;
  logic             r_borrow;
  logic             r_y;
  logic             w_bout;
  logic             w_last;

  sub_borrow_cell u_cell (
    .x    (r_x[0]),
    .z    (r_z[0]),
    .bin  (r_borrow),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_x      <= '0;
      r_z      <= '0;
      r_borrow <= 1'b0;
      r_y      <= 1'b0;
    end else if (flush) begin
      // Abort wins over everything, including a capture in IDLE; Y keeps its old value.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // LT/LE swap operand roles so a single borrow chain serves all four ops.
            r_x      <= op[1] ? B : A;
            r_z      <= op[1] ? A : B;
            r_borrow <= op[0];
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_borrow <= w_bout;
          r_x      <= r_x >> 1;
          r_z      <= r_z >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_y     <= w_bout;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_BUSY);
  assign Y         = r_y;

endmodule

// File: tb/tb_gt_uint_bitserial_ctrl.sv
// Self-checking bench for gt_uint_bitserial_ctrl: vector table, corner sequences, random jobs.
module tb_gt_uint_bitserial_ctrl;
  import gt_bitserial_pkg::*;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         exp_y;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, flush, out_valid, out_ready, y, busy;
  logic [W-1:0] a, b;
  logic [1:0]   op;

  logic         in_valid2, in_ready2, out_valid2, out_ready2, y2, busy2;
  logic [1:0]   a2, b2, op2;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  gt_uint_bitserial_ctrl #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .op        (op),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (y),
    .busy      (busy)
  );

  gt_uint_bitserial_ctrl #(.WIDTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .A         (a2),
    .B         (b2),
    .op        (op2),
    .flush     (1'b0),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .Y         (y2),
    .busy      (busy2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [1:0] mop);
    case (mop)
      2'd0:    return ma > mb;
      2'd1:    return ma >= mb;
      2'd2:    return ma < mb;
      default: return ma <= mb;
    endcase
  endfunction

  // Scoreboard: push on accept, drop on flush of a live job, pop on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush && (busy || out_valid)) begin
        sb_q.delete();
      end else if (out_valid && out_ready) begin
        check("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) check("scoreboard_y", y, sb_q.pop_front());
      end
      if (in_valid && in_ready && !flush) sb_q.push_back(model(a, b, op));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] iop);
    int t;
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check("accepted", in_ready, 1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the job must not see these.
    a = W'($urandom); b = W'($urandom); op = 2'($urandom);
  endtask

  // Edges counted from the one after the accepting edge; W here is cycle WIDTH+1
  // counting the accept cycle as cycle 0.
  task automatic wait_done(output int lat);
    int leaked;
    lat = 0; leaked = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) leaked++;
      tick();
      lat++;
    end
    check("in_ready_low_while_busy", leaked, 0);
  endtask

  vec_t vecs[11];

  initial begin
    int lat, bad, badlat;
    logic yh;
    logic [W-1:0] ra, rb;
    logic [1:0] rop;

    vecs[0]  = '{16'h8000, 16'h7FFF, OP_GT, 1'b1, "gt_msb"};
    vecs[1]  = '{16'h1234, 16'h1234, OP_GT, 1'b0, "eq_gt"};
    vecs[2]  = '{16'h1234, 16'h1234, OP_GE, 1'b1, "eq_ge"};
    vecs[3]  = '{16'h1234, 16'h1234, OP_LT, 1'b0, "eq_lt"};
    vecs[4]  = '{16'h1234, 16'h1234, OP_LE, 1'b1, "eq_le"};
    vecs[5]  = '{16'h0000, 16'hFFFF, OP_LT, 1'b1, "zero_lt_max"};
    vecs[6]  = '{16'h0000, 16'hFFFF, OP_GT, 1'b0, "zero_gt_max"};
    vecs[7]  = '{16'hFFFF, 16'hFFFF, OP_LE, 1'b1, "max_le_max"};
    vecs[8]  = '{16'hFFFF, 16'h0000, OP_LE, 1'b0, "max_le_zero"};
    vecs[9]  = '{16'h0001, 16'h0000, OP_GE, 1'b1, "lsb_ge"};
    vecs[10] = '{16'h8000, 16'h8001, OP_GE, 1'b0, "close_ge"};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; op2 = '0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_done(lat);
      check({vecs[i].name, "_latency"}, lat, W);
      check({vecs[i].name, "_y"}, y, vecs[i].exp_y);
      tick();
      check({vecs[i].name, "_out_valid_drop"}, out_valid, 0);
      check({vecs[i].name, "_in_ready_back"}, in_ready, 1);
    end

    // Flush mid-BUSY: result dropped, follow-up job unaffected.
    send(16'd5, 16'd3, OP_GT);
    repeat (7) tick();
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    bad = 0;
    repeat (25) begin
      if (out_valid) bad++;
      tick();
    end
    check("flush_no_out_valid", bad, 0);
    send(16'd2, 16'd9, OP_LE);
    wait_done(lat);
    check("after_flush_latency", lat, W);
    check("after_flush_y", y, 1);
    tick();

    // Backpressure: result held, new job refused until handshake.
    out_ready = 1'b0;
    send(16'h00F0, 16'h000F, OP_GT);
    wait_done(lat);
    yh = y;
    check("hold_y", yh, 1);
    a = '0; b = '0; op = OP_GT; in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (!out_valid || y !== yh || in_ready) bad++;
    end
    check("hold_stable", bad, 0);
    out_ready = 1'b1;
    tick();
    check("hold_release_out_valid", out_valid, 0);
    check("hold_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("held_job_accepted", busy, 1);
    wait_done(lat);
    check("held_job_latency", lat, W);
    check("held_job_y", y, 0);
    tick();

    // Async reset mid-BUSY after a Y=1 result.
    send(16'hFFFF, 16'h0000, OP_GT);
    wait_done(lat);
    check("pre_reset_y", y, 1);
    tick();
    send(16'd1, 16'd2, OP_LT);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", y, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    tick();

    badlat = 0;
    for (int j = 0; j < 1000; j++) begin
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rop = 2'($urandom_range(0, 3));
      out_ready = 1'b0;
      send(ra, rb, rop);
      wait_done(lat);
      if (lat != W) badlat++;
      repeat ($urandom_range(0, 2)) tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("random_latency_errors", badlat, 0);
    check("random_sb_drained", sb_q.size(), 0);

    // WIDTH=2 instance.
    a2 = 2'b11; b2 = 2'b10; op2 = OP_GE; in_valid2 = 1'b1;
    check("w2_in_ready", in_ready2, 1);
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    check("w2_latency", lat, 2);
    check("w2_y", y2, 1);
    out_ready2 = 1'b1;
    tick();
    check("w2_out_valid_drop", out_valid2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
